// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine that owns the architectural HI/LO registers.
// Define MULTDIV_FAST_MUL_EN to give multiplies a single-cycle path (IDLE->FIX->DONE).
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic               isDiv_q;
    logic               negRes_q;
    logic               negRem_q;
    logic               bZero_q;
    logic [WIDTH-1:0]   aRaw_q;
    logic [WIDTH-1:0]   aMag_q;
    logic [WIDTH-1:0]   bMag_q;
    logic [2*WIDTH-1:0] prod_q;
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   quo_q;

    logic               signedOp;
    logic               aNeg;
    logic               bNeg;
    logic [WIDTH-1:0]   aMag_d;
    logic [WIDTH-1:0]   bMag_d;
    logic [WIDTH:0]     mulSum;
    logic [WIDTH:0]     divShift;
    logic               divFits;
    logic [WIDTH-1:0]   divDiff;
    logic [2*WIDTH-1:0] prodRaw;
    logic [2*WIDTH-1:0] prodFix;
    logic [WIDTH-1:0]   remFix;
    logic [WIDTH-1:0]   quoFix;

    // Operand magnitudes at launch, one shift-add / restoring step, and the FIX-stage sign correction.
    always_comb begin
        signedOp = ~op[0];
        aNeg     = signedOp & a[WIDTH-1];
        bNeg     = signedOp & b[WIDTH-1];
        aMag_d   = aNeg ? -a : a;
        bMag_d   = bNeg ? -b : b;

        mulSum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, aMag_q} : '0);

        // The partial remainder is 33 bits wide: the shifted remainder plus the next dividend bit.
        divShift = {rem_q, quo_q[WIDTH-1]};
        divFits  = divShift >= {1'b0, bMag_q};
        divDiff  = divShift[WIDTH-1:0] - bMag_q;

`ifdef MULTDIV_FAST_MUL_EN
        prodRaw  = {{WIDTH{1'b0}}, aMag_q} * {{WIDTH{1'b0}}, bMag_q};
`else
        prodRaw  = prod_q;
`endif
        prodFix  = negRes_q ? -prodRaw : prodRaw;
        remFix   = negRem_q ? -rem_q : rem_q;
        quoFix   = negRes_q ? -quo_q : quo_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            isDiv_q     <= 1'b0;
            negRes_q    <= 1'b0;
            negRem_q    <= 1'b0;
            bZero_q     <= 1'b0;
            aRaw_q      <= '0;
            aMag_q      <= '0;
            bMag_q      <= '0;
            prod_q      <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (start) begin
                        isDiv_q  <= op[1];
                        negRes_q <= aNeg ^ bNeg;
                        negRem_q <= aNeg;
                        bZero_q  <= (b == '0);
                        aRaw_q   <= a;
                        aMag_q   <= aMag_d;
                        bMag_q   <= bMag_d;
                        prod_q   <= {{WIDTH{1'b0}}, bMag_d};
                        rem_q    <= '0;
                        quo_q    <= aMag_d;
                        cnt_q    <= '0;
                        busy     <= 1'b1;
`ifdef MULTDIV_FAST_MUL_EN
                        state_q  <= op[1] ? ITER : FIX;
`else
                        state_q  <= ITER;
`endif
                    end
                end
                ITER: begin
                    if (isDiv_q) begin
                        rem_q <= divFits ? divDiff : divShift[WIDTH-1:0];
                        quo_q <= {quo_q[WIDTH-2:0], divFits};
                    end else begin
                        prod_q <= {mulSum, prod_q[WIDTH-1:1]};
                    end
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) state_q <= FIX;
                end
                FIX: begin
                    // Divide by zero bypasses the iterative result so HI holds the untouched dividend.
                    if (isDiv_q && bZero_q) begin
                        hi          <= aRaw_q;
                        lo          <= '1;
                        div_by_zero <= 1'b1;
                    end else if (isDiv_q) begin
                        hi <= remFix;
                        lo <= quoFix;
                    end else begin
                        hi <= prodFix[2*WIDTH-1:WIDTH];
                        lo <= prodFix[WIDTH-1:0];
                    end
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_q <= DONE;
                end
                DONE: begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    div_by_zero <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: a cycle-level behavioural model checked every cycle,
// plus directed operations with hand-computed HI/LO, flag and latency values.
module tb_mult_div_unit;
`ifdef MULTDIV_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 34;
`endif
    localparam int DIV_LAT = 34;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic [31:0] wdata = '0;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad = 0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Architectural result of one operation as {div_by_zero, HI, LO}, from plain arithmetic.
    function automatic logic [64:0] modelResult(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx;
        longint      sy;
        logic [63:0] p;
        logic [63:0] q;
        logic [63:0] r;
        logic [64:0] res;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (o == 2'b00) begin
            p = sx * sy;
            res = {1'b0, p};
        end else if (o == 2'b01) begin
            p = {32'b0, x} * {32'b0, y};
            res = {1'b0, p};
        end else if (y == 32'd0) begin
            res = {1'b1, x, 32'hFFFF_FFFF};
        end else begin
            if (o == 2'b10) begin
                q = sx / sy;
                r = sx % sy;
            end else begin
                q = {32'b0, x} / {32'b0, y};
                r = {32'b0, x} % {32'b0, y};
            end
            res = {1'b0, r[31:0], q[31:0]};
        end
        return res;
    endfunction

    logic [31:0] mHi = '0;
    logic [31:0] mLo = '0;
    logic        mBusy = 1'b0;
    logic        mDone = 1'b0;
    logic        mDbz = 1'b0;
    logic [64:0] pend = '0;
    int          age = 0;
    int          lat = DIV_LAT;
    bit          checkEn = 1'b0;

    // Model: age counts cycles since the accepted start; the result lands when age reaches the latency.
    always @(posedge clk) begin
        if (reset) begin
            mHi = '0; mLo = '0; mBusy = 1'b0; mDone = 1'b0; mDbz = 1'b0;
            age = 0;
            checkEn = 1'b1;
        end else begin
            mDone = 1'b0;
            mDbz = 1'b0;
            if (age == 0 || age == lat) begin
                if (hi_we) mHi = wdata;
                if (lo_we) mLo = wdata;
            end
            if (age == 0) begin
                if (start) begin
                    pend = modelResult(op, a, b);
                    lat = op[1] ? DIV_LAT : MUL_LAT;
                    age = 1;
                    mBusy = 1'b1;
                end
            end else if (age == lat) begin
                age = 0;
            end else begin
                age++;
                if (age == lat) begin
                    mHi = pend[63:32];
                    mLo = pend[31:0];
                    mDbz = pend[64];
                    mDone = 1'b1;
                    mBusy = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (checkEn) begin
            checkValue("model.busy", {31'b0, busy}, {31'b0, mBusy});
            checkValue("model.done", {31'b0, done}, {31'b0, mDone});
            checkValue("model.dbz", {31'b0, div_by_zero}, {31'b0, mDbz});
            checkValue("model.hi", hi, mHi);
            checkValue("model.lo", lo, mLo);
        end
    end

    task automatic applyStimulus(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, output int cyc);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (done !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic checkOutput(input string name, input int cyc, input int expCyc,
                               input logic [31:0] expHi, input logic [31:0] expLo, input logic expDbz);
        checkValue({name, ".done"}, {31'b0, done}, 32'd1);
        checkValue({name, ".latency"}, 32'(cyc), 32'(expCyc));
        checkValue({name, ".hi"}, hi, expHi);
        checkValue({name, ".lo"}, lo, expLo);
        checkValue({name, ".dbz"}, {31'b0, div_by_zero}, {31'b0, expDbz});
        checkValue({name, ".busy"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        int cyc;
        int doneCnt;
        int doneAt;
        logic [31:0] capHi;
        logic [31:0] capLo;

        repeat (2) @(negedge clk);
        checkValue("reset.hi", hi, 32'd0);
        checkValue("reset.lo", lo, 32'd0);
        checkValue("reset.busy", {31'b0, busy}, 32'd0);
        checkValue("reset.done", {31'b0, done}, 32'd0);
        reset = 1'b0;

        applyStimulus(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc);
        checkOutput("multu_max", cyc, MUL_LAT, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        applyStimulus(2'b00, 32'hFFFF_FFFD, 32'd5, cyc);
        checkOutput("mult_neg", cyc, MUL_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
        applyStimulus(2'b10, 32'hFFFF_FFF9, 32'd2, cyc);
        checkOutput("div_neg", cyc, DIV_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        applyStimulus(2'b11, 32'd7, 32'd2, cyc);
        checkOutput("divu", cyc, DIV_LAT, 32'd1, 32'd3, 1'b0);
        applyStimulus(2'b11, 32'd5, 32'd0, cyc);
        checkOutput("divu_zero", cyc, DIV_LAT, 32'd5, 32'hFFFF_FFFF, 1'b1);
        applyStimulus(2'b10, 32'hFFFF_FFFB, 32'd0, cyc);
        checkOutput("div_zero", cyc, DIV_LAT, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1);
        applyStimulus(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
        checkOutput("div_ovf", cyc, DIV_LAT, 32'd0, 32'h8000_0000, 1'b0);
        applyStimulus(2'b00, 32'd100000, 32'hFFFF_FFFE, cyc);
        checkOutput("mult_mix", cyc, MUL_LAT, 32'hFFFF_FFFF, 32'hFFFC_F2C0, 1'b0);

        // Start held through the DONE cycle is only taken once the unit is back in IDLE.
        op = 2'b11; a = 32'd9; b = 32'd4; start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (done !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("start_in_done", cyc, DIV_LAT, 32'd1, 32'd2, 1'b0);

        @(negedge clk);
        hi_we = 1'b1; wdata = 32'h0000_1234;
        @(negedge clk);
        hi_we = 1'b0;
        checkValue("mthi.hi", hi, 32'h0000_1234);
        checkValue("mthi.lo", lo, 32'd2);

        // A second start mid-operation is dropped: exactly one done and the first operation's result.
        @(negedge clk);
        op = 2'b11; a = 32'd100; b = 32'd7; start = 1'b1;
        @(negedge clk);
        doneCnt = 0; doneAt = 0; capHi = '0; capLo = '0;
        for (int i = 1; i <= 60; i++) begin
            if (i == 5) begin
                op = 2'b01; a = 32'd3; b = 32'd3; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1) begin
                doneCnt++; doneAt = i; capHi = hi; capLo = lo;
            end
            @(negedge clk);
        end
        start = 1'b0;
        checkValue("restart.doneCount", 32'(doneCnt), 32'd1);
        checkValue("restart.doneCycle", 32'(doneAt), 32'd34);
        checkValue("restart.hi", capHi, 32'd2);
        checkValue("restart.lo", capLo, 32'd14);

        // MTLO while busy is ignored.
        op = 2'b11; a = 32'd42; b = 32'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (done !== 1'b1 && cyc < 100) begin
            lo_we = (cyc == 3);
            wdata = 32'h0000_ABCD;
            @(negedge clk);
            cyc++;
        end
        lo_we = 1'b0;
        checkOutput("mtlo_busy", cyc, DIV_LAT, 32'd2, 32'd8, 1'b0);

        // Reset mid-operation aborts it, clears HI/LO and no done follows.
        @(negedge clk);
        op = 2'b11; a = 32'd1000; b = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkValue("midreset.busy", {31'b0, busy}, 32'd0);
        checkValue("midreset.hi", hi, 32'd0);
        checkValue("midreset.lo", lo, 32'd0);
        doneCnt = 0;
        repeat (50) begin
            @(negedge clk);
            if (done === 1'b1) doneCnt++;
        end
        checkValue("midreset.noDone", 32'(doneCnt), 32'd0);

        applyStimulus(2'b01, 32'd6, 32'd7, cyc);
        checkOutput("after_reset", cyc, MUL_LAT, 32'd0, 32'd42, 1'b0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
